// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with valid/ready flow control. Each stage resolves one
// CW-bit chunk and registers the carry into the next stage.
module addsub_pipe #(
  parameter int DWIDTH     = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              op,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] sum,
  output logic              carry,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int CW = DWIDTH / NUM_STAGES;

  if ((NUM_STAGES < 1) || (NUM_STAGES > DWIDTH) || ((DWIDTH % NUM_STAGES) != 0)) begin : g_bad_cfg
    $error("addsub_pipe: DWIDTH must be a multiple of NUM_STAGES");
  end

  logic [DWIDTH-1:0]     b_eff;
  logic [NUM_STAGES-1:0] valid_vec;
  logic                  stall;

  assign b_eff    = in2 ^ {DWIDTH{op}};
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  genvar gi;
  for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    // PW: operand bits not yet consumed on entry to this stage (this chunk and above)
    localparam int PW = DWIDTH - gi * CW;
    localparam int SW = (gi + 1) * CW;

    logic [PW-1:0] a_pend;
    logic [PW-1:0] b_pend;
    logic          c_in;
    logic          v_in;
    logic          a_msb_in;
    logic          b_msb_in;
    logic [CW:0]   chunk;
    logic [SW-1:0] s_d, s_q;
    logic          c_d, c_q;
    logic          v_d, v_q;
    logic          a_msb_d, a_msb_q;
    logic          b_msb_d, b_msb_q;

    if (gi == 0) begin : g_src
      assign a_pend   = in1;
      assign b_pend   = b_eff;
      assign c_in     = cin ^ op;
      assign v_in     = in_valid;
      assign a_msb_in = in1[DWIDTH-1];
      assign b_msb_in = b_eff[DWIDTH-1];
      always_comb begin
        s_d = chunk[CW-1:0];
      end
    end else begin : g_src
      assign a_pend   = g_stage[gi-1].g_ops.a_q;
      assign b_pend   = g_stage[gi-1].g_ops.b_q;
      assign c_in     = g_stage[gi-1].c_q;
      assign v_in     = g_stage[gi-1].v_q;
      assign a_msb_in = g_stage[gi-1].a_msb_q;
      assign b_msb_in = g_stage[gi-1].b_msb_q;
      always_comb begin
        s_d = {chunk[CW-1:0], g_stage[gi-1].s_q};
      end
    end

    always_comb begin
      chunk   = {1'b0, a_pend[CW-1:0]} + {1'b0, b_pend[CW-1:0]} + {{CW{1'b0}}, c_in};
      c_d     = chunk[CW];
      v_d     = v_in;
      a_msb_d = a_msb_in;
      b_msb_d = b_msb_in;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q     <= '0;
        c_q     <= 1'b0;
        v_q     <= 1'b0;
        a_msb_q <= 1'b0;
        b_msb_q <= 1'b0;
      end else if (!stall) begin
        s_q     <= s_d;
        c_q     <= c_d;
        v_q     <= v_d;
        a_msb_q <= a_msb_d;
        b_msb_q <= b_msb_d;
      end
    end

    // Upper operand chunks ride along until the stage that consumes them.
    if (gi < NUM_STAGES - 1) begin : g_ops
      logic [PW-CW-1:0] a_d, a_q;
      logic [PW-CW-1:0] b_d, b_q;

      always_comb begin
        a_d = a_pend[PW-1:CW];
        b_d = b_pend[PW-1:CW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    assign valid_vec[gi] = v_q;
  end

  assign sum       = g_stage[NUM_STAGES-1].s_q;
  assign carry     = g_stage[NUM_STAGES-1].c_q;
  assign out_valid = valid_vec[NUM_STAGES-1];
  assign busy      = |valid_vec;
  assign ovf       = (g_stage[NUM_STAGES-1].a_msb_q == g_stage[NUM_STAGES-1].b_msb_q) &
                     (sum[DWIDTH-1] != g_stage[NUM_STAGES-1].a_msb_q);

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (4, 1 and 16 stages) checked every cycle
// against a whole-word arithmetic model with a per-instance latency line.
module tb_addsub_pipe;
  localparam int NI = 3;
  localparam int NS_TAB [NI] = '{4, 1, 16};

  logic        clk;
  logic        rst;
  logic [15:0] in1_a [NI];
  logic [15:0] in2_a [NI];
  logic [15:0] sum_a [NI];
  logic        op_a [NI];
  logic        cin_a [NI];
  logic        in_valid_a [NI];
  logic        in_ready_a [NI];
  logic        carry_a [NI];
  logic        ovf_a [NI];
  logic        out_valid_a [NI];
  logic        out_ready_a [NI];
  logic        busy_a [NI];

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    addsub_pipe #(.DWIDTH(16), .NUM_STAGES(NS_TAB[gi])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in1       (in1_a[gi]),
      .in2       (in2_a[gi]),
      .op        (op_a[gi]),
      .cin       (cin_a[gi]),
      .in_valid  (in_valid_a[gi]),
      .in_ready  (in_ready_a[gi]),
      .sum       (sum_a[gi]),
      .carry     (carry_a[gi]),
      .ovf       (ovf_a[gi]),
      .out_valid (out_valid_a[gi]),
      .out_ready (out_ready_a[gi]),
      .busy      (busy_a[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        o;
    logic        c;
    logic [15:0] s;
  } slot_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  slot_t       mdl [NI][16];
  int          hs_cnt [NI];
  logic [17:0] dir_q [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  vec_t dvec [6] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0}
  };

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, carry, sum} from signed/unsigned integer arithmetic.
  function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                         input logic o, input logic c);
    int ua, ub, ci, r, sr;
    logic cy, ov;
    logic [15:0] s;
    ua = int'(a);
    ub = int'(b);
    ci = c ? 1 : 0;
    if (!o) begin
      r  = ua + ub + ci;
      sr = int'($signed(a)) + int'($signed(b)) + ci;
      cy = (r > 65535);
    end else begin
      r  = ua - ub - ci;
      sr = int'($signed(a)) - int'($signed(b)) - ci;
      cy = (r >= 0);
    end
    s  = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, cy, s};
  endfunction

  // Reference: results march through a line of NS slots; the whole line freezes on a stall.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        for (int j = 0; j < 16; j++) mdl[k][j] <= '0;
      end else if (!(mdl[k][NS_TAB[k]-1].v && !out_ready_a[k])) begin
        for (int j = NS_TAB[k] - 1; j > 0; j--) mdl[k][j] <= mdl[k][j-1];
        mdl[k][0] <= {in_valid_a[k], golden(in1_a[k], in2_a[k], op_a[k], cin_a[k])};
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      automatic slot_t       last     = mdl[k][NS_TAB[k]-1];
      automatic logic        exp_busy = 1'b0;
      automatic logic [17:0] dexp;
      for (int j = 0; j < NS_TAB[k]; j++) exp_busy |= mdl[k][j].v;
      check_val($sformatf("out_valid[%0d]", k), out_valid_a[k], last.v);
      check_val($sformatf("busy[%0d]", k), busy_a[k], exp_busy);
      check_val($sformatf("in_ready[%0d]", k), in_ready_a[k], !(last.v && !out_ready_a[k]));
      if (last.v) begin
        check_val($sformatf("sum[%0d]", k), sum_a[k], last.s);
        check_val($sformatf("carry[%0d]", k), carry_a[k], last.c);
        check_val($sformatf("ovf[%0d]", k), ovf_a[k], last.o);
        if (out_ready_a[k]) begin
          hs_cnt[k]++;
          $display("ns=%0d beat %0d: sum=%04h carry=%b ovf=%b", NS_TAB[k], hs_cnt[k],
                   sum_a[k], carry_a[k], ovf_a[k]);
          if (k == 0 && dir_q.size() > 0) begin
            dexp = dir_q.pop_front();
            check_val("dir_sum", sum_a[0], dexp[15:0]);
            check_val("dir_carry", carry_a[0], dexp[16]);
            check_val("dir_ovf", ovf_a[0], dexp[17]);
          end
        end
      end
    end
  end

  // All drive tasks start and end at 1ns after a rising edge.
  task automatic drive_beat(input int k, input logic [15:0] a, input logic [15:0] b,
                            input logic o, input logic c);
    int   g = 0;
    logic rdy;
    in1_a[k]      = a;
    in2_a[k]      = b;
    op_a[k]       = o;
    cin_a[k]      = c;
    in_valid_a[k] = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready_a[k];
      @(posedge clk);
      #1;
      g++;
    end while (!rdy && g < 200);
    if (!rdy) check_val($sformatf("accept_wait[%0d]", k), g, 0);
  endtask

  task automatic idle(input int k);
    in_valid_a[k] = 1'b0;
    in1_a[k]      = 16'($urandom);
    in2_a[k]      = 16'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int k, input int target);
    int g = 0;
    while (hs_cnt[k] < target && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (hs_cnt[k] < target) check_val($sformatf("drain_count[%0d]", k), hs_cnt[k], target);
  endtask

  task automatic rand_run(input int k, input int n);
    int   base = hs_cnt[k];
    logic done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) idle(k);
          drive_beat(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end
        idle(k);
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready_a[k] = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready_a[k] = 1'b1;
      end
    join
    wait_drain(k, base + n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in1_a[k] = '0; in2_a[k] = '0; op_a[k] = 1'b0; cin_a[k] = 1'b0;
      in_valid_a[k] = 1'b0; out_ready_a[k] = 1'b1; hs_cnt[k] = 0;
    end
    #2;
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("rst_out_valid[%0d]", k), out_valid_a[k], 0);
      check_val($sformatf("rst_busy[%0d]", k), busy_a[k], 0);
      check_val($sformatf("rst_in_ready[%0d]", k), in_ready_a[k], 1);
      check_val($sformatf("rst_sum[%0d]", k), sum_a[k], 0);
      check_val($sformatf("rst_carry[%0d]", k), carry_a[k], 0);
      check_val($sformatf("rst_ovf[%0d]", k), ovf_a[k], 0);
    end
    #12 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors; the first one alone measures latency.
    dir_q.push_back({dvec[0].o, dvec[0].c, dvec[0].s});
    drive_beat(0, dvec[0].a, dvec[0].b, dvec[0].op, dvec[0].cin);
    in_valid_a[0] = 1'b0;
    lat = 1;
    while (!out_valid_a[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency_ns4", lat, 4);
    for (int i = 1; i < 6; i++) begin
      dir_q.push_back({dvec[i].o, dvec[i].c, dvec[i].s});
      drive_beat(0, dvec[i].a, dvec[i].b, dvec[i].op, dvec[i].cin);
    end
    idle(0);
    wait_drain(0, 6);

    // Back-to-back stream with a 3-cycle output stall after the 2nd result.
    base = hs_cnt[0];
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          dir_q.push_back({2'b00, 16'(i + 256 * i)});
          drive_beat(0, 16'(i), 16'(256 * i), 1'b0, 1'b0);
        end
        idle(0);
      end
      begin
        int g = 0;
        while (hs_cnt[0] < base + 2 && g < 200) begin
          @(posedge clk);
          #1;
          g++;
        end
        out_ready_a[0] = 1'b0;
        repeat (3) begin
          #1 check_val("stall_in_ready", in_ready_a[0], 0);
          @(posedge clk);
          #1;
        end
        out_ready_a[0] = 1'b1;
      end
    join
    wait_drain(0, base + 8);
    check_val("busy_after_drain", busy_a[0], 0);

    // Asynchronous reset mid-cycle with three beats in flight.
    out_ready_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(0, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
    idle(0);
    check_val("pre_rst_out_valid", out_valid_a[0], 1);
    #3 rst = 1'b1;
    #2;
    check_val("async_rst_out_valid", out_valid_a[0], 0);
    check_val("async_rst_busy", busy_a[0], 0);
    check_val("async_rst_sum", sum_a[0], 0);
    check_val("async_rst_in_ready", in_ready_a[0], 1);
    #2 rst = 1'b0;
    out_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    base = hs_cnt[0];
    dir_q.push_back({2'b00, 16'h0300});
    drive_beat(0, 16'h0100, 16'h0200, 1'b0, 1'b0);
    dir_q.push_back({2'b01, 16'h0FFF});
    drive_beat(0, 16'h1000, 16'h0001, 1'b1, 1'b0);
    idle(0);
    wait_drain(0, base + 2);
    check_val("dir_q_empty", dir_q.size(), 0);

    // Random runs with random backpressure on all three depths at once.
    fork
      rand_run(0, 300);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_val($sformatf("final_busy[%0d]", k), busy_a[k], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
